instru_line_cache: RTL and testbench
====================================

INSTRU_LINE_CACHE -- requirements
Module: instru_line_cache

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per line (power of two, >=2); the line is filled as one BRAM burst.
REQ-002 SHALL have parameter LINES, default 4, meaning number of direct-mapped lines (power of two, >=1).
REQ-003 SHALL have port clk  input  1  sole clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone slave strobe, cycle and write-enable.
REQ-006 SHALL have port wbs_dat_i  input  32  Wishbone write data (ignored).
REQ-007 SHALL have port wbs_adr_i  input  32  byte address; offset = adr[2 +: log2(LINE_WORDS)], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-008 SHALL have ports wbs_ack_o  output  1, and wbs_dat_o  output  32  read acknowledge and data.
REQ-009 SHALL have port wbs_cache_miss  output  1  fill request to the arbiter.
REQ-010 SHALL have port miss_adr_o  output  32  line-aligned fill address (offset bits and adr[1:0] zero).
REQ-011 SHALL have ports bram_data_in  input  32, and bram_in_valid  input  1  fill words from the BRAM controller, one per valid cycle, in ascending offset order.
REQ-012 SHALL have port flush_i  input  1  single-cycle invalidate-all.

Function
REQ-013 SHALL implement state machine IDLE / FILL.
REQ-014 Read request = stb & cyc & ~we & ~wbs_ack_o; a hit means valid[index] and stored tag == tag.
REQ-015 IDLE, read hit: wbs_ack_o SHALL pulse high exactly one cycle on the next edge, with wbs_dat_o = the addressed word; state stays IDLE.
REQ-016 IDLE, read miss: SHALL go to FILL next edge, latching index, tag, miss_adr_o; fill counter = 0.
REQ-017 FILL: wbs_cache_miss SHALL be high from FILL entry until the first bram_in_valid is accepted, low otherwise.
REQ-018 FILL: each bram_in_valid SHALL write bram_data_in to word[counter] of the latched line and increment counter.
REQ-019 On the LINE_WORDS-th word: valid[index] and tag SHALL be set, state SHALL go to IDLE; the pending request re-looks-up as a hit and is acked one cycle later (total miss latency = LINE_WORDS valid beats + 2 cycles).
REQ-020 bram_in_valid in IDLE SHALL be ignored (no storage, no counter change).
REQ-021 Request withdrawn (cyc or stb low) during FILL: fill SHALL still complete and validate the line; no ack is produced.
REQ-022 Writes (stb & cyc & we) SHALL never be acked; a write whose index/tag hits a valid line SHALL clear that valid bit next edge (self-modifying-code coherence).
REQ-023 flush_i SHALL clear all valid bits next edge; flush during FILL clears all valid bits, but the in-flight line is still validated on completion; flush coincident with completion leaves only that line valid.
REQ-024 Write-invalidate of the line being filled SHALL be overridden by fill completion in the same cycle (line ends valid).
REQ-025 wbs_dat_o SHALL hold its last value when wbs_ack_o is low.

Reset
REQ-026 While rst is high at an edge: state = IDLE, all valid bits = 0, fill counter = 0, wbs_ack_o = 0, wbs_dat_o = 0, wbs_cache_miss = 0, miss_adr_o = 0.
REQ-027 Reset mid-FILL SHALL abandon the fill; the line stays invalid; later bram_in_valid beats are ignored per REQ-020.
REQ-028 Data array contents SHALL not be reset.

Configuration
REQ-029 Macro ICACHE_STATS_EN defined: SHALL add outputs hit_cnt_o  16  (increments on each wbs_ack_o) and miss_cnt_o  16  (increments on each FILL entry); both saturate at 0xFFFF and reset to 0.
REQ-030 Macro ICACHE_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Cold read of 0x3800_0024 (defaults) -> wbs_cache_miss high, miss_adr_o = 0x3800_0020; after 8 beats D0..D7, ack with wbs_dat_o = D1, 2 cycles after last beat.
REQ-032 Then read 0x3800_003C -> ack next cycle with D7, no wbs_cache_miss.
REQ-033 Read 0x3800_00A4 (same index 1, new tag) -> refill at 0x3800_00A0; a following read of 0x3800_0024 misses again.
REQ-034 Write to 0x3800_0028 while its line is valid -> no ack; next read of 0x3800_0024 misses.
REQ-035 flush_i pulse after filling lines 0 and 1 -> reads to both miss; rst asserted after 3 fill beats -> outputs 0, next read restarts a full 8-beat fill.
REQ-036 With ICACHE_STATS_EN: 3 misses + 5 hits -> miss_cnt_o = 3, hit_cnt_o = 8.

Source files
------------

// File: rtl/instru_line_cache.sv
// rtl/instru_line_cache.sv - direct-mapped instruction line cache with Wishbone read port and burst BRAM refill
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module instru_line_cache #(
  parameter int LINE_WORDS = 8,
  parameter int LINES      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_cache_miss,
  output logic [31:0] miss_adr_o,
  input  logic [31:0] bram_data_in,
  input  logic        bram_in_valid,
  input  logic        flush_i
`ifdef ICACHE_STATS_EN
  ,output logic [15:0] hit_cnt_o
  ,output logic [15:0] miss_cnt_o
`endif
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_LSB  = 2 + OFF_W + IDX_BITS;
  localparam int TAG_W    = 32 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4) - 32'd1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tags [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];
  logic [IDX_W-1:0] r_fill_idx;
  logic [TAG_W-1:0] r_fill_tag;
  logic [OFF_W-1:0] r_cnt;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_miss;
  logic [31:0]      r_miss_adr;

  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_beat;
  logic             w_fill_done;
  logic             w_miss_entry;
  logic             w_unused;

  generate
    if (IDX_BITS > 0) begin : g_idx
      assign w_idx = wbs_adr_i[2+OFF_W +: IDX_W];
    end else begin : g_idx_single
      assign w_idx = '0;
    end
  endgenerate

  assign w_off        = wbs_adr_i[2 +: OFF_W];
  assign w_tag        = wbs_adr_i[31:TAG_LSB];
  assign w_hit        = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_rd_req     = wbs_stb_i & wbs_cyc_i & ~wbs_we_i & ~r_ack;
  assign w_wr_req     = wbs_stb_i & wbs_cyc_i & wbs_we_i;
  assign w_beat       = (r_state == ST_FILL) & bram_in_valid;
  assign w_fill_done  = w_beat & (r_cnt == LAST_WORD);
  assign w_miss_entry = (r_state == ST_IDLE) & w_rd_req & ~w_hit;
  assign w_unused     = ^{wbs_dat_i, wbs_adr_i[1:0]};

  // Line storage is deliberately not reset; the valid bits alone govern hits.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_data[r_fill_idx][r_cnt] <= bram_data_in;
    end
    if (w_fill_done) begin
      r_tags[r_fill_idx] <= r_fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_valid    <= '0;
      r_fill_idx <= '0;
      r_fill_tag <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_dat      <= 32'h0;
      r_miss     <= 1'b0;
      r_miss_adr <= 32'h0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_req) begin
            if (w_hit) begin
              r_ack <= 1'b1;
              r_dat <= r_data[w_idx][w_off];
            end else begin
              // Victim line goes invalid now so an abandoned fill never leaves mixed data visible.
              r_state        <= ST_FILL;
              r_fill_idx     <= w_idx;
              r_fill_tag     <= w_tag;
              r_miss_adr     <= wbs_adr_i & ~LINE_MASK;
              r_cnt          <= '0;
              r_miss         <= 1'b1;
              r_valid[w_idx] <= 1'b0;
            end
          end
        end
        default: begin
          if (bram_in_valid) begin
            r_cnt  <= r_cnt + OFF_W'(1);
            r_miss <= 1'b0;
            if (r_cnt == LAST_WORD) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase

      // Ordering gives fill completion priority over flush and write-invalidate.
      if (w_wr_req && w_hit) begin
        r_valid[w_idx] <= 1'b0;
      end
      if (flush_i) begin
        r_valid <= '0;
      end
      if (w_fill_done) begin
        r_valid[r_fill_idx] <= 1'b1;
      end
    end
  end

  assign wbs_ack_o      = r_ack;
  assign wbs_dat_o      = r_dat;
  assign wbs_cache_miss = r_miss;
  assign miss_adr_o     = r_miss_adr;

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 16'h0;
      r_miss_cnt <= 16'h0;
    end else begin
      if (r_ack && (r_hit_cnt != 16'hFFFF)) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_miss_entry && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_instru_line_cache.sv
// tb/tb_instru_line_cache.sv - scoreboard bench for instru_line_cache against a line-level reference model
module tb_instru_line_cache;

  localparam int LW = 8;
  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbs_cache_miss;
  logic [31:0] miss_adr_o;
  logic [31:0] bram_data_in = 32'h0;
  logic        bram_in_valid = 1'b0;
  logic        flush_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_o;
  logic [15:0] miss_cnt_o;
`endif

  instru_line_cache #(.LINE_WORDS(LW), .LINES(NL)) dut (
    .clk(clk), .rst(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .wbs_cache_miss(wbs_cache_miss), .miss_adr_o(miss_adr_o),
    .bram_data_in(bram_data_in), .bram_in_valid(bram_in_valid),
    .flush_i(flush_i)
`ifdef ICACHE_STATS_EN
    ,.hit_cnt_o(hit_cnt_o)
    ,.miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_dat = 32'h0;

  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] m_line  [NL][LW];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % NL);
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'((a / 4) % LW);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LW * NL);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic logic [31:0] rnd_adr();
    return 32'h3800_0000 + 32'($urandom_range(0, 2)) * 32'h80 + 32'($urandom_range(0, 31)) * 32'd4;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every ack must match the oldest expected read; data must hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_dat = 32'h0;
    end else if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack data %h want no ack at %0t", wbs_dat_o, $time);
      end else begin
        chk("ack_data", wbs_dat_o, exp_q.pop_front());
      end
      last_dat = wbs_dat_o;
    end else begin
      chk("dat_hold", wbs_dat_o, last_dat);
    end
  end

  // Called at a negedge; holds rst across two edges and checks cleared outputs.
  task automatic reset_body();
    rst = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    bram_in_valid = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_miss", 32'(wbs_cache_miss), 32'd0);
    chk("rst_miss_adr", miss_adr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(negedge clk);
      bram_in_valid = 1'($urandom_range(0, 1));
      bram_data_in = $urandom;
    end
    @(negedge clk);
    bram_in_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = a; wbs_dat_i = $urandom;
    @(negedge clk);
    chk("wr_no_ack", 32'(wbs_ack_o), 32'd0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    if (m_hit(a)) m_valid[idx_of(a)] = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    m_clear();
  endtask

  // mode: 0 plain, 1 flush mid-fill, 2 flush on last beat, 3 write on last beat,
  //       4 withdraw mid-fill, 5 reset mid-fill
  task automatic do_read(input logic [31:0] a, input int mode);
    logic [31:0] w [LW];
    int i;
    int beats;
    bit v;
    bit fl_done;
    i = idx_of(a);
    @(negedge clk);
    if (m_hit(a)) begin
      exp_q.push_back(m_line[i][off_of(a)]);
      m_hits++;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a;
      @(negedge clk);
      chk("hit_ack", 32'(wbs_ack_o), 32'd1);
      chk("hit_no_fill", 32'(wbs_cache_miss), 32'd0);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      if (!wbs_ack_o) begin
        exp_q.delete();
        reset_body();
      end
      return;
    end
    for (int k = 0; k < LW; k++) w[k] = $urandom;
    if (mode <= 2) begin
      exp_q.push_back(w[off_of(a)]);
      m_hits++;
    end
    m_misses++;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = a;
    @(negedge clk);
    chk("miss_req", 32'(wbs_cache_miss), 32'd1);
    chk("miss_adr", miss_adr_o, a - (a % (4 * LW)));
    chk("miss_no_ack", 32'(wbs_ack_o), 32'd0);
    beats = 0;
    fl_done = 1'b0;
    while (beats < LW) begin
      if (mode == 5 && beats == 3) break;
      v = ($urandom_range(0, 3) != 0);
      if ((mode == 2 || mode == 3) && beats == LW - 1) v = 1'b1;
      if (mode == 1 && beats == 2 && !fl_done) begin
        flush_i = 1'b1;
        fl_done = 1'b1;
      end
      if (mode == 2 && beats == LW - 1) flush_i = 1'b1;
      if (mode == 3 && beats == LW - 1) wbs_we_i = 1'b1;
      if (mode == 4 && beats >= 3) begin
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end
      bram_in_valid = v;
      bram_data_in = v ? w[beats] : $urandom;
      @(posedge clk);
      if (v) beats++;
      @(negedge clk);
      flush_i = 1'b0;
      bram_in_valid = 1'b0;
      chk("fill_req", 32'(wbs_cache_miss), 32'(beats == 0));
      if (beats < LW) chk("fill_no_ack", 32'(wbs_ack_o), 32'd0);
    end
    if (mode == 5) begin
      reset_body();
      for (int k = 3; k < LW; k++) begin
        bram_in_valid = 1'b1;
        bram_data_in = $urandom;
        @(negedge clk);
      end
      bram_in_valid = 1'b0;
      return;
    end
    if (mode == 1 || mode == 2) m_clear();
    m_valid[i] = 1'b1;
    m_tag[i] = tag_of(a);
    for (int k = 0; k < LW; k++) m_line[i][k] = w[k];
    if (mode <= 2) begin
      chk("ack_not_early", 32'(wbs_ack_o), 32'd0);
      @(negedge clk);
      chk("miss_latency", 32'(wbs_ack_o), 32'd1);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    end else begin
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    reset_body();

    do_read(32'h3800_0024, 0);
    do_read(32'h3800_003C, 0);
    do_read(32'h3800_00A4, 0);
    do_read(32'h3800_0024, 0);
    do_write(32'h3800_0028);
    do_read(32'h3800_0024, 0);
    do_read(32'h3800_0004, 0);
    do_flush();
    do_read(32'h3800_0004, 0);
    do_read(32'h3800_0024, 0);
    do_read(32'h3800_0044, 5);
    do_read(32'h3800_0044, 0);
    do_read(32'h3800_0064, 1);
    do_read(32'h3800_0004, 0);
    do_read(32'h3800_00E4, 2);
    do_read(32'h3800_0024, 0);
    do_read(32'h3800_00C0, 3);
    do_read(32'h3800_00C4, 0);
    do_read(32'h3800_0010, 4);
    do_read(32'h3800_0014, 0);
    idle_noise(6);
    do_read(32'h3800_0018, 0);

    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) do_read(rnd_adr(), 0);
      else if (r < 68) do_read(rnd_adr(), $urandom_range(1, 5));
      else if (r < 80) do_write(rnd_adr());
      else if (r < 84) do_flush();
      else if (r < 87) begin
        @(negedge clk);
        reset_body();
      end else idle_noise($urandom_range(1, 4));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", 32'(hit_cnt_o), 32'(m_hits));
    chk("miss_cnt", 32'(miss_cnt_o), 32'(m_misses));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion want finish by 2ms");
    $fatal(1, "timeout");
  end

endmodule
